// File: rtl/lnrv_icb_splt.sv
// ICB splitter: one master fanned out to P_ICB_COUNT address-decoded slaves with
// up to P_OTS_COUNT outstanding commands. Unmapped addresses go to a built-in error responder.
module lnrv_icb_splt #(
  parameter int unsigned P_ADDR_WIDTH = 32,
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_ICB_COUNT  = 4,
  parameter int unsigned P_OTS_COUNT  = 4,
  parameter logic [31:0] P_ERR_RDATA  = 32'hDEAD_BEEF
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     m_icb_cmd_vld,
  output logic                                     m_icb_cmd_rdy,
  input  logic                                     m_icb_cmd_write,
  input  logic [P_ADDR_WIDTH-1:0]                  m_icb_cmd_addr,
  input  logic [P_DATA_WIDTH-1:0]                  m_icb_cmd_wdata,
  input  logic [P_DATA_WIDTH/8-1:0]                m_icb_cmd_wstrb,
  output logic                                     m_icb_rsp_vld,
  input  logic                                     m_icb_rsp_rdy,
  output logic [P_DATA_WIDTH-1:0]                  m_icb_rsp_rdata,
  output logic                                     m_icb_rsp_err,
  output logic [P_ICB_COUNT-1:0]                   sn_icb_cmd_vld,
  input  logic [P_ICB_COUNT-1:0]                   sn_icb_cmd_rdy,
  output logic [P_ICB_COUNT-1:0]                   sn_icb_cmd_write,
  output logic [P_ADDR_WIDTH*P_ICB_COUNT-1:0]      sn_icb_cmd_addr,
  output logic [P_DATA_WIDTH*P_ICB_COUNT-1:0]      sn_icb_cmd_wdata,
  output logic [P_DATA_WIDTH/8*P_ICB_COUNT-1:0]    sn_icb_cmd_wstrb,
  input  logic [P_ICB_COUNT-1:0]                   sn_icb_rsp_vld,
  output logic [P_ICB_COUNT-1:0]                   sn_icb_rsp_rdy,
  input  logic [P_ICB_COUNT-1:0]                   sn_icb_rsp_err,
  input  logic [P_DATA_WIDTH*P_ICB_COUNT-1:0]      sn_icb_rsp_rdata,
  input  logic [P_ADDR_WIDTH*P_ICB_COUNT-1:0]      sn_region_base,
  input  logic [P_ADDR_WIDTH*P_ICB_COUNT-1:0]      sn_region_end,
  output logic [$clog2(P_OTS_COUNT+1)-1:0]         ots_cnt,
  output logic                                     busy
);

  localparam int unsigned AW = P_ADDR_WIDTH;
  localparam int unsigned DW = P_DATA_WIDTH;
  localparam int unsigned SW = P_DATA_WIDTH / 8;
  localparam int unsigned N  = P_ICB_COUNT;
  localparam int unsigned CW = $clog2(P_OTS_COUNT + 1);
  localparam int unsigned TW = $clog2(P_ICB_COUNT + 1);

  localparam logic [TW-1:0] TGT_ERR   = TW'(N);
  localparam logic [CW-1:0] CNT_MAX   = CW'(P_OTS_COUNT);
  localparam logic [DW-1:0] ERR_RDATA = DW'(P_ERR_RDATA);

  logic [CW-1:0] cnt;
  logic [TW-1:0] tgt;
  logic [TW-1:0] sel;
  logic [N-1:0]  match;
  logic          sel_rdy;
  logic          allow;
  logic          cmd_hs;
  logic          rsp_hs;

  assign ots_cnt = cnt;
  assign busy    = (cnt != '0);
  assign cmd_hs  = m_icb_cmd_vld & m_icb_cmd_rdy;
  assign rsp_hs  = m_icb_rsp_vld & m_icb_rsp_rdy;

  // Address decode: lowest matching index wins; an end of zero on the last slave makes it the default
  always_comb begin
    match = '0;
    sel   = TGT_ERR;
    for (int i = 0; i < int'(N); i++) begin
      match[i] = (sn_region_base[i*AW +: AW] <= m_icb_cmd_addr) &&
                 (m_icb_cmd_addr < sn_region_end[i*AW +: AW]);
    end
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (match[i]) sel = TW'(i);
    end
    if ((match == '0) && (sn_region_end[(N-1)*AW +: AW] == '0)) sel = TW'(N - 1);
  end

  // Same-target streaming keeps responses in order; the last pending pop lets a new target in early
  always_comb begin
    allow = (cnt < CNT_MAX) &&
            ((cnt == '0) || (sel == tgt) || ((cnt == CW'(1)) && rsp_hs));
    sel_rdy = (sel == TGT_ERR);
    for (int i = 0; i < int'(N); i++) begin
      if (sel == TW'(i)) sel_rdy = sn_icb_cmd_rdy[i];
    end
    m_icb_cmd_rdy = m_icb_cmd_vld & allow & sel_rdy;
  end

  // Command fan-out: only the selected slave sees the command fields
  always_comb begin
    sn_icb_cmd_vld   = '0;
    sn_icb_cmd_write = '0;
    sn_icb_cmd_addr  = '0;
    sn_icb_cmd_wdata = '0;
    sn_icb_cmd_wstrb = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (sel == TW'(i)) begin
        sn_icb_cmd_vld[i]            = m_icb_cmd_vld & allow;
        sn_icb_cmd_write[i]          = m_icb_cmd_write;
        sn_icb_cmd_addr[i*AW +: AW]  = m_icb_cmd_addr;
        sn_icb_cmd_wdata[i*DW +: DW] = m_icb_cmd_wdata;
        sn_icb_cmd_wstrb[i*SW +: SW] = m_icb_cmd_wstrb;
      end
    end
  end

  // Response return from the current target, or the error responder
  always_comb begin
    m_icb_rsp_vld   = 1'b0;
    m_icb_rsp_rdata = '0;
    m_icb_rsp_err   = 1'b0;
    sn_icb_rsp_rdy  = '0;
    if (tgt == TGT_ERR) begin
      m_icb_rsp_vld   = busy;
      m_icb_rsp_err   = 1'b1;
      m_icb_rsp_rdata = ERR_RDATA;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (tgt == TW'(i)) begin
          m_icb_rsp_vld     = busy & sn_icb_rsp_vld[i];
          m_icb_rsp_rdata   = sn_icb_rsp_rdata[i*DW +: DW];
          m_icb_rsp_err     = sn_icb_rsp_err[i];
          sn_icb_rsp_rdy[i] = busy & m_icb_rsp_rdy;
        end
      end
    end
  end

  // Outstanding tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      tgt <= '0;
    end else begin
      if (cmd_hs) tgt <= sel;
      if (cmd_hs && !rsp_hs) cnt <= cnt + CW'(1);
      else if (!cmd_hs && rsp_hs) cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_lnrv_icb_splt.sv
// Directed bench for lnrv_icb_splt with a response scoreboard.
module tb_lnrv_icb_splt;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              m_icb_cmd_vld, m_icb_cmd_rdy, m_icb_cmd_write;
  logic [AW-1:0]     m_icb_cmd_addr;
  logic [DW-1:0]     m_icb_cmd_wdata;
  logic [SW-1:0]     m_icb_cmd_wstrb;
  logic              m_icb_rsp_vld, m_icb_rsp_rdy, m_icb_rsp_err;
  logic [DW-1:0]     m_icb_rsp_rdata;
  logic [N-1:0]      sn_icb_cmd_vld, sn_icb_cmd_rdy, sn_icb_cmd_write;
  logic [AW*N-1:0]   sn_icb_cmd_addr;
  logic [DW*N-1:0]   sn_icb_cmd_wdata;
  logic [SW*N-1:0]   sn_icb_cmd_wstrb;
  logic [N-1:0]      sn_icb_rsp_vld, sn_icb_rsp_rdy, sn_icb_rsp_err;
  logic [DW*N-1:0]   sn_icb_rsp_rdata;
  logic [AW*N-1:0]   sn_region_base, sn_region_end;
  logic [CW-1:0]     ots_cnt;
  logic              busy;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  lnrv_icb_splt dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m_icb_cmd_vld    (m_icb_cmd_vld),
    .m_icb_cmd_rdy    (m_icb_cmd_rdy),
    .m_icb_cmd_write  (m_icb_cmd_write),
    .m_icb_cmd_addr   (m_icb_cmd_addr),
    .m_icb_cmd_wdata  (m_icb_cmd_wdata),
    .m_icb_cmd_wstrb  (m_icb_cmd_wstrb),
    .m_icb_rsp_vld    (m_icb_rsp_vld),
    .m_icb_rsp_rdy    (m_icb_rsp_rdy),
    .m_icb_rsp_rdata  (m_icb_rsp_rdata),
    .m_icb_rsp_err    (m_icb_rsp_err),
    .sn_icb_cmd_vld   (sn_icb_cmd_vld),
    .sn_icb_cmd_rdy   (sn_icb_cmd_rdy),
    .sn_icb_cmd_write (sn_icb_cmd_write),
    .sn_icb_cmd_addr  (sn_icb_cmd_addr),
    .sn_icb_cmd_wdata (sn_icb_cmd_wdata),
    .sn_icb_cmd_wstrb (sn_icb_cmd_wstrb),
    .sn_icb_rsp_vld   (sn_icb_rsp_vld),
    .sn_icb_rsp_rdy   (sn_icb_rsp_rdy),
    .sn_icb_rsp_err   (sn_icb_rsp_err),
    .sn_icb_rsp_rdata (sn_icb_rsp_rdata),
    .sn_region_base   (sn_region_base),
    .sn_region_end    (sn_region_end),
    .ots_cnt          (ots_cnt),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Compare the response currently being handshaken against the scoreboard head
  task automatic rsp_pop();
    exp_t e;
    chk("rsp_hs", 64'(m_icb_rsp_vld & m_icb_rsp_rdy), 64'd1);
    chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_rdata", 64'(m_icb_rsp_rdata), 64'(e.rdata));
      chk("rsp_err", 64'(m_icb_rsp_err), 64'(e.err));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    m_icb_cmd_vld    = 1'b0;
    m_icb_cmd_write  = 1'b0;
    m_icb_cmd_addr   = '0;
    m_icb_cmd_wdata  = '0;
    m_icb_cmd_wstrb  = '0;
    m_icb_rsp_rdy    = 1'b0;
    sn_icb_cmd_rdy   = '0;
    sn_icb_rsp_vld   = '0;
    sn_icb_rsp_err   = '0;
    sn_icb_rsp_rdata = '0;
    sn_region_base   = {32'h3000, 32'h0400, 32'h1000, 32'h0000};
    sn_region_end    = {32'h0000, 32'h3000, 32'h2000, 32'h1000};
    #12;
    chk("rst_ots", 64'(ots_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_vld", 64'(m_icb_rsp_vld), 64'd0);
    chk("rst_sn_vld", 64'(sn_icb_cmd_vld), 64'd0);
    chk("rst_sn_rsp_rdy", 64'(sn_icb_rsp_rdy), 64'd0);
    step();
    reset_n = 1'b1;
    step();

    // Single read routed to slave 1
    sn_icb_cmd_rdy = '1;
    m_icb_cmd_vld  = 1'b1;
    m_icb_cmd_addr = 32'h1004;
    #1;
    chk("t1_sn_vld", 64'(sn_icb_cmd_vld), 64'h2);
    chk("t1_cmd_rdy", 64'(m_icb_cmd_rdy), 64'd1);
    chk("t1_addr1", 64'(sn_icb_cmd_addr[32 +: 32]), 64'h1004);
    chk("t1_addr0", 64'(sn_icb_cmd_addr[0 +: 32]), 64'h0);
    push(32'h1234, 1'b0);
    step();
    m_icb_cmd_vld = 1'b0;
    #1;
    chk("t1_ots1", 64'(ots_cnt), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    sn_icb_rsp_vld = 4'b0010;
    sn_icb_rsp_rdata[32 +: 32] = 32'h1234;
    m_icb_rsp_rdy = 1'b1;
    #1;
    chk("t1_sn_rsp_rdy", 64'(sn_icb_rsp_rdy), 64'h2);
    rsp_pop();
    step();
    sn_icb_rsp_vld = '0;
    #1;
    chk("t1_ots0", 64'(ots_cnt), 64'd0);

    // Spurious responses while idle are never accepted
    sn_icb_rsp_vld = '1;
    #1;
    chk("spur_rdy", 64'(sn_icb_rsp_rdy), 64'd0);
    chk("spur_vld", 64'(m_icb_rsp_vld), 64'd0);
    sn_icb_rsp_vld = '0;
    step();

    // Fill to P_OTS_COUNT on slave 0, fifth command waits for a pop
    m_icb_cmd_vld   = 1'b1;
    m_icb_cmd_write = 1'b1;
    m_icb_cmd_addr  = 32'h10;
    m_icb_cmd_wdata = 32'h55;
    m_icb_cmd_wstrb = 4'hf;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_fill_rdy", 64'(m_icb_cmd_rdy), 64'd1);
      push(32'hA0 + 32'(k), 1'b0);
      step();
    end
    #1;
    chk("t2_full_ots", 64'(ots_cnt), 64'd4);
    chk("t2_full_rdy", 64'(m_icb_cmd_rdy), 64'd0);
    chk("t2_full_vld", 64'(sn_icb_cmd_vld), 64'd0);
    step();
    #1;
    chk("t2_stall_rdy", 64'(m_icb_cmd_rdy), 64'd0);
    sn_icb_rsp_vld = 4'b0001;
    sn_icb_rsp_rdata[0 +: 32] = 32'hA0;
    #1;
    chk("t2_full_pop_rdy", 64'(m_icb_cmd_rdy), 64'd0);
    rsp_pop();
    step();
    sn_icb_rsp_vld = '0;
    #1;
    chk("t2_fifth_rdy", 64'(m_icb_cmd_rdy), 64'd1);
    push(32'hA4, 1'b0);
    step();
    m_icb_cmd_vld = 1'b0;
    #1;
    chk("t2_peak_ots", 64'(ots_cnt), 64'd4);
    for (int k = 1; k < 5; k++) begin
      sn_icb_rsp_vld = 4'b0001;
      sn_icb_rsp_rdata[0 +: 32] = 32'hA0 + 32'(k);
      #1;
      rsp_pop();
      step();
    end
    sn_icb_rsp_vld = '0;
    #1;
    chk("t2_drain_ots", 64'(ots_cnt), 64'd0);

    // Target switch stalls until the final pending response pops
    m_icb_cmd_vld   = 1'b1;
    m_icb_cmd_write = 1'b0;
    m_icb_cmd_addr  = 32'h20;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t3_s0_rdy", 64'(m_icb_cmd_rdy), 64'd1);
      push(32'hB0 + 32'(k), 1'b0);
      step();
    end
    m_icb_cmd_addr = 32'h1008;
    #1;
    chk("t3_stall_rdy", 64'(m_icb_cmd_rdy), 64'd0);
    chk("t3_stall_vld", 64'(sn_icb_cmd_vld), 64'd0);
    sn_icb_rsp_vld = 4'b0001;
    sn_icb_rsp_rdata[0 +: 32] = 32'hB0;
    #1;
    chk("t3_cnt2_rdy", 64'(m_icb_cmd_rdy), 64'd0);
    rsp_pop();
    step();
    sn_icb_rsp_rdata[0 +: 32] = 32'hB1;
    #1;
    chk("t3_switch_rdy", 64'(m_icb_cmd_rdy), 64'd1);
    chk("t3_switch_vld", 64'(sn_icb_cmd_vld), 64'h2);
    rsp_pop();
    push(32'hC0, 1'b1);
    step();
    m_icb_cmd_vld  = 1'b0;
    sn_icb_rsp_vld = '0;
    #1;
    chk("t3_ots1", 64'(ots_cnt), 64'd1);
    sn_icb_rsp_vld = 4'b0011;
    sn_icb_rsp_err = 4'b0010;
    sn_icb_rsp_rdata[32 +: 32] = 32'hC0;
    #1;
    chk("t3_sn_rsp_rdy", 64'(sn_icb_rsp_rdy), 64'h2);
    rsp_pop();
    step();
    sn_icb_rsp_vld = '0;
    sn_icb_rsp_err = '0;
    #1;
    chk("t3_ots0", 64'(ots_cnt), 64'd0);

    // Unmapped address: error responder, back-to-back
    sn_region_end[96 +: 32] = 32'h4000;
    sn_icb_cmd_rdy = '0;
    m_icb_cmd_vld  = 1'b1;
    m_icb_cmd_addr = 32'h9000;
    #1;
    chk("t4_rdy", 64'(m_icb_cmd_rdy), 64'd1);
    chk("t4_sn_vld", 64'(sn_icb_cmd_vld), 64'd0);
    chk("t4_rsp_vld0", 64'(m_icb_rsp_vld), 64'd0);
    push(32'hDEADBEEF, 1'b1);
    step();
    #1;
    chk("t4_sn_rsp_rdy", 64'(sn_icb_rsp_rdy), 64'd0);
    chk("t4_b2b_rdy", 64'(m_icb_cmd_rdy), 64'd1);
    rsp_pop();
    push(32'hDEADBEEF, 1'b1);
    step();
    m_icb_cmd_vld = 1'b0;
    #1;
    rsp_pop();
    step();
    #1;
    chk("t4_ots0", 64'(ots_cnt), 64'd0);
    chk("t4_rsp_idle", 64'(m_icb_rsp_vld), 64'd0);

    // Overlap priority and default slave
    sn_region_end[96 +: 32] = 32'h0;
    m_icb_cmd_vld  = 1'b1;
    m_icb_cmd_addr = 32'h500;
    #1;
    chk("t5_overlap", 64'(sn_icb_cmd_vld), 64'h1);
    m_icb_cmd_addr = 32'h2800;
    #1;
    chk("t5_region2", 64'(sn_icb_cmd_vld), 64'h4);
    m_icb_cmd_addr = 32'h9000;
    #1;
    chk("t5_default", 64'(sn_icb_cmd_vld), 64'h8);
    m_icb_cmd_vld = 1'b0;
    step();

    // Reset with three outstanding drops all tracking
    sn_icb_cmd_rdy = '1;
    m_icb_cmd_vld  = 1'b1;
    m_icb_cmd_addr = 32'h2800;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t6_fill_rdy", 64'(m_icb_cmd_rdy), 64'd1);
      step();
    end
    m_icb_cmd_vld  = 1'b0;
    m_icb_rsp_rdy  = 1'b0;
    sn_icb_rsp_vld = 4'b0100;
    #1;
    chk("t6_ots3", 64'(ots_cnt), 64'd3);
    chk("t6_rsp_vld", 64'(m_icb_rsp_vld), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_ots", 64'(ots_cnt), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_rsp_vld", 64'(m_icb_rsp_vld), 64'd0);
    chk("t6_rst_sn_rsp_rdy", 64'(sn_icb_rsp_rdy), 64'd0);
    sn_icb_rsp_vld = '0;
    step();
    reset_n        = 1'b1;
    m_icb_cmd_vld  = 1'b1;
    m_icb_cmd_addr = 32'h1004;
    #1;
    chk("t6_post_rdy", 64'(m_icb_cmd_rdy), 64'd1);
    chk("t6_post_vld", 64'(sn_icb_cmd_vld), 64'h2);
    push(32'hD0, 1'b0);
    step();
    m_icb_cmd_vld = 1'b0;
    #1;
    chk("t6_post_ots", 64'(ots_cnt), 64'd1);
    sn_icb_rsp_vld = 4'b0010;
    sn_icb_rsp_rdata[32 +: 32] = 32'hD0;
    m_icb_rsp_rdy = 1'b1;
    #1;
    rsp_pop();
    step();
    sn_icb_rsp_vld = '0;
    #1;
    chk("t6_end_ots", 64'(ots_cnt), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
